// File: rtl/calc_arbiter.sv
// calc_arbiter: two requesters share one signed arithmetic unit.
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   reqN_valid/reqN_ready            command handshake per requester (N = 0, 1)
//   reqN_op, reqN_a, reqN_b          opcode (00 ADD, 01 SUB, 10 MUL, 11 DIV) and W-bit signed operands
//   res_valid/res_ready              result handshake
//   res_id, res_data, res_err        owning requester, 2W-bit signed result, divide-by-zero flag
//   busy                             high whenever an operation is in flight or awaiting pickup
module calc_arbiter #(
   parameter int W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_valid,
   input  logic                  req1_valid,
   output logic                  req0_ready,
   output logic                  req1_ready,
   input  logic [1:0]            req0_op,
   input  logic [1:0]            req1_op,
   input  logic [W-1:0]          req0_a,
   input  logic [W-1:0]          req0_b,
   input  logic [W-1:0]          req1_a,
   input  logic [W-1:0]          req1_b,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic                  res_id,
   output logic signed [2*W-1:0] res_data,
   output logic                  res_err,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;
   localparam int CW = (W > 2) ? $clog2(W) : 1;
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   state_t state, state_nx;

   logic          ptr;        // 1: req1 wins a tie
   logic          gnt;
   logic          hs;
   logic [1:0]    sel_op;
   logic [W-1:0]  sel_a, sel_b;

   logic [1:0]    op_r;
   logic [W-1:0]  a_r, b_r;
   logic          id_r;

   logic [W-1:0]  dq;         // dividend magnitude shifting out, quotient shifting in
   logic [W-1:0]  dvs;
   logic [W-1:0]  rem;
   logic          neg;
   logic [CW-1:0] cnt;
   logic          div_long;

   logic [W:0]    rem_sh, diff;
   logic          qbit;
   logic [W-1:0]  q_mag;
   logic [2*W-1:0] qz;
   logic signed [2*W-1:0] ax, bx, alu, q_res;

   always_comb begin
      if (req0_valid && req1_valid) gnt = ptr;
      else                          gnt = req1_valid;
      sel_op = gnt ? req1_op : req0_op;
      sel_a  = gnt ? req1_a  : req0_a;
      sel_b  = gnt ? req1_b  : req0_b;
   end

   assign div_long = (op_r == OP_DIV) && (b_r != '0);

   always_comb begin
      state_nx   = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      hs         = 1'b0;
      case (state)
         IDLE: begin
            if (req0_valid || req1_valid) begin
               hs         = 1'b1;
               req0_ready = ~gnt;
               req1_ready = gnt;
               state_nx   = EXEC;
            end
         end
         EXEC: begin
            if (!div_long || cnt == LAST) state_nx = DONE;
         end
         DONE: begin
            if (res_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign busy      = (state != IDLE);
   assign res_valid = (state == DONE);

   always_comb begin
      ax = {{W{a_r[W-1]}}, a_r};
      bx = {{W{b_r[W-1]}}, b_r};
      case (op_r)
         OP_ADD:  alu = ax + bx;
         OP_SUB:  alu = ax - bx;
         OP_MUL:  alu = ax * bx;
         default: alu = '0;
      endcase
      // one restoring step: shift next dividend bit into the partial remainder
      rem_sh = {rem, dq[W-1]};
      diff   = rem_sh - {1'b0, dvs};
      qbit   = ~diff[W];
      q_mag  = {dq[W-2:0], qbit};
      qz     = {{W{1'b0}}, q_mag};
      q_res  = neg ? -qz : qz;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr      <= 1'b0;
         op_r     <= '0;
         a_r      <= '0;
         b_r      <= '0;
         id_r     <= 1'b0;
         dq       <= '0;
         dvs      <= '0;
         rem      <= '0;
         neg      <= 1'b0;
         cnt      <= '0;
         res_data <= '0;
         res_err  <= 1'b0;
         res_id   <= 1'b0;
      end else if (hs) begin
         op_r <= sel_op;
         a_r  <= sel_a;
         b_r  <= sel_b;
         id_r <= gnt;
         ptr  <= ~gnt;
         // magnitudes of the most negative value still fit in W unsigned bits
         dq   <= sel_a[W-1] ? -sel_a : sel_a;
         dvs  <= sel_b[W-1] ? -sel_b : sel_b;
         neg  <= sel_a[W-1] ^ sel_b[W-1];
         rem  <= '0;
         cnt  <= '0;
      end else if (state == EXEC) begin
         if (div_long) begin
            rem <= qbit ? diff[W-1:0] : rem_sh[W-1:0];
            dq  <= q_mag;
            cnt <= cnt + CW'(1);
            if (cnt == LAST) begin
               res_data <= q_res;
               res_err  <= 1'b0;
               res_id   <= id_r;
            end
         end else begin
            res_data <= alu;
            res_err  <= (op_r == OP_DIV);
            res_id   <= id_r;
         end
      end
   end

endmodule
